// File: rtl/wb_gcd_pkg.sv
// Shared definitions for the Wishbone GCD responder: register offsets,
// CTRL bit positions and the engine state encoding.
package wb_gcd_pkg;

   localparam logic [7:0] A_OFF      = 8'h00;
   localparam logic [7:0] B_OFF      = 8'h04;
   localparam logic [7:0] CTRL_OFF   = 8'h08;
   localparam logic [7:0] RESULT_OFF = 8'h0C;
   localparam logic [7:0] CYCLES_OFF = 8'h10;

   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_DONE_BIT   = 1;
   localparam int unsigned CTRL_IRQEN_BIT  = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } gcd_state_e;

   // Word-aligned offset match; the two byte-address LSBs are ignored.
   function automatic logic off_hit(input logic [7:0] off, input logic [7:0] reg_off);
      return off[7:2] == reg_off[7:2];
   endfunction

endpackage

// File: rtl/gcd_sub_core.sv
// Subtractive GCD engine: one subtract/compare step per RUN cycle,
// with a saturating count of RUN cycles for the last computation.
module gcd_sub_core
   import wb_gcd_pkg::*;
#(
   parameter int unsigned BITS = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   output logic            busy_o,
   output logic            done_pulse_o,
   output logic [BITS-1:0] result_o,
   output logic [BITS-1:0] cycles_o
);

   localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

   gcd_state_e      state_q, state_d;
   logic [BITS-1:0] x_q, x_d;
   logic [BITS-1:0] y_q, y_d;
   logic [BITS-1:0] result_q, result_d;
   logic [BITS-1:0] cycles_q, cycles_d;

   // State and datapath registers; reset aborts any computation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
         cycles_q <= cycles_d;
      end
   end

   // Next state: load operands on start, then one Euclid step per cycle.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
      cycles_d = cycles_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d  = RUN;
               x_d      = a_i;
               y_d      = b_i;
               cycles_d = '0;
            end
         end
         RUN: begin
            if (cycles_q != '1) begin
               cycles_d = cycles_q + ONE;
            end
            if (x_q == '0) begin
               result_d = y_q;
               state_d  = IDLE;
            end else if (y_q == '0) begin
               result_d = x_q;
               state_d  = IDLE;
            end else if (x_q >= y_q) begin
               x_d = x_q - y_q;
            end else begin
               y_d = y_q - x_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: busy while running, done pulse on the terminating RUN cycle.
   always_comb begin
      busy_o       = (state_q == RUN);
      done_pulse_o = (state_q == RUN) && ((x_q == '0) || (y_q == '0));
      result_o     = result_q;
      cycles_o     = cycles_q;
   end

endmodule

// File: rtl/wb_gcd_responder.sv
// Wishbone responder exposing operand, control, result and cycle-count
// registers of the GCD engine inside a 256-byte address window.
module wb_gcd_responder
   import wb_gcd_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned BITS      = 32
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        irq_o
);

   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic            irq_en_q, irq_en_d;
   logic            done_q, done_d;

   logic            hit, access, wr, rd, ctrl_wr, start, done_clr;
   logic [7:0]      off;
   logic [31:0]     rdata;
   logic            busy, done_pulse;
   logic [BITS-1:0] result, cycles;
   logic            unused_adr_lsb;

   assign unused_adr_lsb = ^wbs_adr_i[1:0];

   assign off      = wbs_adr_i[7:0];
   assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign access   = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
   assign wr       = access & wbs_we_i;
   assign rd       = access & ~wbs_we_i;
   assign ctrl_wr  = wr & off_hit(off, CTRL_OFF) & wbs_sel_i[0];
   assign start    = ctrl_wr & wbs_dat_i[CTRL_START_BIT] & ~busy;
   assign done_clr = ctrl_wr & wbs_dat_i[CTRL_DONE_BIT];

   gcd_sub_core #(
      .BITS(BITS)
   ) u_core (
      .clk_i        (wb_clk_i),
      .rst_i        (wb_rst_i),
      .start_i      (start),
      .a_i          (a_q),
      .b_i          (b_q),
      .busy_o       (busy),
      .done_pulse_o (done_pulse),
      .result_o     (result),
      .cycles_o     (cycles)
   );

   // Read mux over the register map; unmapped offsets read as zero.
   always_comb begin
      rdata = '0;
      case (off[7:2])
         A_OFF[7:2]:      rdata = a_q;
         B_OFF[7:2]:      rdata = b_q;
         CTRL_OFF[7:2]:   rdata = {29'd0, irq_en_q, done_q, busy};
         RESULT_OFF[7:2]: rdata = result;
         CYCLES_OFF[7:2]: rdata = cycles;
         default:         rdata = '0;
      endcase
   end

   // Next-state for bus response and software-visible registers.
   // done: engine completion beats both start and DONE_CLR; start beats DONE_CLR.
   always_comb begin
      ack_d    = access;
      dat_d    = rd ? rdata : '0;
      a_d      = a_q;
      b_d      = b_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (wr && wbs_sel_i[i] && off_hit(off, A_OFF)) begin
            a_d[i*8 +: 8] = wbs_dat_i[i*8 +: 8];
         end
         if (wr && wbs_sel_i[i] && off_hit(off, B_OFF)) begin
            b_d[i*8 +: 8] = wbs_dat_i[i*8 +: 8];
         end
      end
      if (ctrl_wr) begin
         irq_en_d = wbs_dat_i[CTRL_IRQEN_BIT];
      end
      if (done_pulse) begin
         done_d = 1'b1;
      end else if (start || done_clr) begin
         done_d = 1'b0;
      end
   end

   // Register update; reset clears everything and suppresses any ack.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         dat_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         a_q      <= a_d;
         b_q      <= b_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = done_q & irq_en_q;

endmodule
